serial_logic_unit: RTL and testbench
====================================

Name: serial_logic_unit

Overview:
- Bit-serial WIDTH-bit logic unit. It accepts two operands and a 2-bit op code through a valid/ready handshake.
- It applies the per-bit function (AND, OR, XOR, NOT a) one bit per cycle, LSB first, through a single 1-bit cell.
- It returns the WIDTH-bit result through an output valid/ready handshake.
- It is the issuing and collecting end for the team's 1-bit logic cell. It sits between the operand register file and the result bus of the practice datapath.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range is 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored when op=2'b11.
- op  input  2  2'b00 AND, 2'b01 OR, 2'b10 XOR, 2'b11 NOT a.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  computed result.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, bit counter=0, operand shift registers=0, latched op=0.
- FSM states:
  - IDLE: in_ready=1. If in_valid=1, latch a, b and op; clear the counter and result; go to RUN.
  - RUN: each cycle, the cell computes f(a_sh[0], b_sh[0], op_q). The output bit shifts into result at the MSB while result shifts right. a_sh and b_sh shift right. The counter increments. After the WIDTH-th RUN cycle (counter==WIDTH-1), go to DONE.
  - DONE: out_valid=1 and result is held stable. If out_ready=1, go to IDLE.
- Handshake rules:
  - in_ready is high only in IDLE. in_valid outside IDLE is ignored and not queued.
  - A DONE→IDLE transfer and a new accept never happen in the same cycle.
  - out_valid stays high until out_ready is sampled high; it drops the cycle after.
- Latency and throughput:
  - An accept at edge N produces out_valid high after edge N+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles.
- Bit ordering: after WIDTH shifts, result[i] = f(a[i], b[i]).
- Widths: the counter is max(1,$clog2(WIDTH)) bits wide. For WIDTH=1, RUN lasts exactly one cycle.
- Input stability: a, b and op may change freely after acceptance; only the latched copies are used.
- Reset mid-operation: abort immediately (asynchronously). No partial result is ever presented.
- Output stability: result is not cleared on leaving DONE. It keeps its last value until the next accept.

Optional Feature:
- Macro: SERIAL_LOGIC_ZERO_FLAG_EN.
- With the macro defined:
  - Adds output port zero (1 bit).
  - A sticky "any-one" flop is cleared on accept and set when any RUN output bit is 1.
  - zero = out_valid & ~any_one.
  - zero resets to 0.
- Without the macro: the port and the flop do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package (lu_pkg) holds:
  - Op encoding constants: LU_OP_AND=2'b00, LU_OP_OR=2'b01, LU_OP_XOR=2'b10, LU_OP_NOT=2'b11.
  - State encoding: S_IDLE, S_RUN, S_DONE.
- One sub-module, lu_bit_cell. It is purely combinational: out = f(a, b, op) per the encoding above. It is instantiated once.
- The FSM, counter and shift registers stay in serial_logic_unit.

Test Plan:
- WIDTH=8, op=00, a=8'hF0, b=8'h3C, out_ready=1 → out_valid high 8 cycles after the accept edge; result=8'h30; then back to IDLE with in_ready=1.
- op=01, a=8'hA5, b=8'h0F → result=8'hAF. Then op=10, a=8'hFF, b=8'h0F → result=8'hF0. Both are issued back-to-back; the second accept comes no earlier than WIDTH+2 cycles after the first.
- op=11, a=8'h5A, b=8'hFF → result=8'hA5. Changing b during RUN has no effect.
- Backpressure: out_ready=0 for 5 cycles in DONE → result, out_valid and busy are held; in_ready=0; an in_valid pulse is ignored. Raising out_ready → one transfer, then IDLE.
- Assert reset at the 4th RUN cycle → out_valid=0, result=0, in_ready=1 immediately. The next operation (AND 8'hFF, 8'h81) gives 8'h81.
- With SERIAL_LOGIC_ZERO_FLAG_EN: AND 8'hF0, 8'h0F → result=0, zero=1 with out_valid. XOR 8'h01, 8'h00 → zero=0. WIDTH=1: OR 1'b0, 1'b1 → result=1 after one RUN cycle.

Source files
------------

// File: rtl/lu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lu_pkg
//  Description : Shared definitions for the bit-serial logic unit: op-code
//                encoding and controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lu_pkg;

    // Per-bit function selected by the 2-bit op code
    localparam logic [1:0] LU_OP_AND = 2'b00;
    localparam logic [1:0] LU_OP_OR  = 2'b01;
    localparam logic [1:0] LU_OP_XOR = 2'b10;
    localparam logic [1:0] LU_OP_NOT = 2'b11;

    // Controller states, explicitly encoded
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } lu_state_t;

endpackage : lu_pkg
`default_nettype wire

// File: rtl/lu_bit_cell.sv
`default_nettype none
// ============================================================================
//  Module      : lu_bit_cell
//  Description : Combinational 1-bit logic cell. Computes AND / OR / XOR of
//                the two input bits, or the inverse of i_a, as chosen by i_op.
//  Revision    : 1.0 - initial release
// ============================================================================
module lu_bit_cell
    import lu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic [1:0] i_op,
    output logic       o_out
);

    // Select the per-bit function; i_b is don't-care for the NOT op
    always_comb begin
        o_out = 1'b0;
        case (i_op)
            LU_OP_AND: o_out = i_a & i_b;
            LU_OP_OR:  o_out = i_a | i_b;
            LU_OP_XOR: o_out = i_a ^ i_b;
            LU_OP_NOT: o_out = ~i_a;
            default:   o_out = 1'b0;
        endcase
    end

endmodule : lu_bit_cell
`default_nettype wire

// File: rtl/serial_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_logic_unit
//  Description : Bit-serial WIDTH-bit logic unit. Accepts two operands and an
//                op code over a valid/ready handshake, feeds one bit per cycle
//                (LSB first) through a single lu_bit_cell, and returns the
//                assembled result over an output valid/ready handshake.
//                Optional feature macro: SERIAL_LOGIC_ZERO_FLAG_EN adds a
//                'zero' output flagging an all-zero result while out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_logic_unit
    import lu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    // Counter must hold WIDTH-1; a single-bit counter is kept for WIDTH=1
    localparam int              c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    lu_state_t          r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [1:0]         r_op;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_bit;
    logic [WIDTH-1:0]   w_result_next;

    // Single shared cell evaluates the current LSB pair
    lu_bit_cell u_cell (
        .i_a   (r_a_sh[0]),
        .i_b   (r_b_sh[0]),
        .i_op  (r_op),
        .o_out (w_bit)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit i lands at i
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_result_next = w_bit;
        end else begin : g_shift_wn
            assign w_result_next = {w_bit, r_result[WIDTH-1:1]};
        end
    endgenerate

    // Controller: accept in IDLE, shift WIDTH times in RUN, present in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_op        <= LU_OP_AND;
            r_cnt       <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh     <= a;
                        r_b_sh     <= b;
                        r_op       <= op;
                        r_cnt      <= '0;
                        r_result   <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_result <= w_result_next;
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_cnt_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result is held; going to IDLE never accepts in the same cycle
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic r_any_one;

    // Sticky flag: remembers whether any produced bit of this op was 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_any_one <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_any_one <= 1'b0;
        end else if (r_state == S_RUN && w_bit) begin
            r_any_one <= 1'b1;
        end
    end

    assign zero = r_out_valid & ~r_any_one;
`endif

endmodule : serial_logic_unit
`default_nettype wire

// File: tb/tb_serial_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_logic_unit
//  Description : Self-checking bench for serial_logic_unit (WIDTH=8 and
//                WIDTH=1 instances). Honours SERIAL_LOGIC_ZERO_FLAG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_logic_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] a, b, result;
    logic [1:0] op;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [0:0] a1, b1, result1;
    logic [1:0] op1;

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic       zero, zero1;
    logic       last_zero;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_logic_unit #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    serial_logic_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .busy(busy1)
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        , .zero(zero1)
`endif
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
        logic       zero_exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one op on the 8-bit unit and check latency and result
    task automatic do_op(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ex, input string nm);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_ready_wait"}, in_ready, 1);
        op = o; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        last_acc = cyc;
        in_valid = 1'b0;
        a = ~av; op = ~o;
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_in_ready_low"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            b = ~b;
            @(posedge clk); #1; lat++;
        end
        chk({nm, "_latency"}, lat, 8);
        chk({nm, "_result"}, result, ex);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        last_zero = zero;
`endif
        if (out_ready) begin
            @(posedge clk); #1;
            chk({nm, "_out_valid_drop"}, out_valid, 0);
            chk({nm, "_in_ready_back"}, in_ready, 1);
        end
    endtask

    initial begin
        int prev_acc;
        logic [7:0] held;

        vecs[0] = '{2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[1] = '{2'b01, 8'hA5, 8'h0F, 8'hAF, 1'b0};
        vecs[2] = '{2'b10, 8'hFF, 8'h0F, 8'hF0, 1'b0};
        vecs[3] = '{2'b11, 8'h5A, 8'hFF, 8'hA5, 1'b0};
        vecs[4] = '{2'b10, 8'h96, 8'h69, 8'hFF, 1'b0};
        vecs[5] = '{2'b01, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{2'b00, 8'hF0, 8'h0F, 8'h00, 1'b1};
        vecs[7] = '{2'b10, 8'h01, 8'h00, 8'h01, 1'b0};

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; op1 = '0; out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        chk("rst_zero", zero, 0);
`endif
        @(negedge clk) reset = 1'b0;

        // Table: issued back-to-back as fast as the handshake allows
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
            if (i > 0) chk($sformatf("vec%0d_interval", i), last_acc - prev_acc, 10);
            prev_acc = last_acc;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
            chk($sformatf("vec%0d_zero", i), last_zero, vecs[i].zero_exp);
`endif
        end

        // Backpressure: hold DONE for 5 cycles, stray in_valid is ignored
        out_ready = 1'b0;
        do_op(2'b00, 8'h3C, 8'hFF, 8'h3C, "bp");
        held = result;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'b01; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_valid", k), out_valid, 1);
            chk($sformatf("bp_hold%0d_result", k), result, held);
            chk($sformatf("bp_hold%0d_busy", k), busy, 1);
            chk($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_result_kept", result, 8'h3C);
        @(posedge clk); #1;
        chk("bp_no_queued_op", busy, 0);

        // Reset during the 4th RUN cycle
        op = 2'b01; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_partial", result, 8'hE0);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk) reset = 1'b0;
        do_op(2'b00, 8'hFF, 8'h81, 8'h81, "post_rst");

        // WIDTH=1: RUN lasts exactly one cycle
        op1 = 2'b01; a1 = 1'b0; b1 = 1'b1; in_valid1 = 1'b1;
        chk("w1_ready", in_ready1, 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("w1_run_busy", busy1, 1);
        chk("w1_run_valid", out_valid1, 0);
        @(posedge clk); #1;
        chk("w1_valid", out_valid1, 1);
        chk("w1_result", result1, 1);
        @(posedge clk); #1;
        chk("w1_idle", in_ready1, 1);
        op1 = 2'b00; a1 = 1'b1; b1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(posedge clk); #1;
        chk("w1_and_valid", out_valid1, 1);
        chk("w1_and_result", result1, 0);
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        chk("w1_and_zero", zero1, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_logic_unit
`default_nettype wire
